// File: rtl/load_store_unit.sv
// Load/store sequencer between a synchronous data memory and the 8x8 register file.
// Optional macro LSU_ADDR_CHECK_EN: addresses >= MEM_DEPTH are rejected through the ERR state.
module load_store_unit #(
   parameter int unsigned AW        = 4,
   parameter int unsigned MEM_DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [2:0]    rd,
   input  logic [AW-1:0] addr,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          rf_write,
   output logic [2:0]    rf_addr,
   output logic [7:0]    rf_wdata,
   input  logic [7:0]    rf_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   localparam int unsigned RW = 3;
   localparam int unsigned DW = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_LD_REQ, S_LD_CAP, S_LD_WB, S_ST_RD, S_ST_WR, S_ERR
   } state_t;

   state_t        state, state_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          range_err_c;
   logic          busy_d, done_d, rf_write_d, mem_en_d, mem_we_d;
   logic [RW-1:0] rf_addr_d;

   // Next state, operand capture, and next-cycle values of the registered outputs
   always_comb begin
      state_d    = state;
      rd_d       = rd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rf_write_d = 1'b0;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      rf_addr_d  = '0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               rd_d   = rd;
               addr_d = addr;
               data_d = '0;
               if (range_err_c) state_d = S_ERR;
               else if (op)     state_d = S_ST_RD;
               else             state_d = S_LD_REQ;
            end
         end
         S_LD_REQ: state_d = S_LD_CAP;
         S_LD_CAP: begin
            data_d  = mem_rdata;
            state_d = S_LD_WB;
         end
         S_LD_WB:  state_d = S_IDLE;
         S_ST_RD: begin
            data_d  = rf_rdata;
            state_d = S_ST_WR;
         end
         S_ST_WR:  state_d = S_IDLE;
         S_ERR:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_LD_WB) || (state_d == S_ST_WR) || (state_d == S_ERR);
      rf_write_d = (state_d == S_LD_WB);
      mem_en_d   = (state_d == S_LD_REQ) || (state_d == S_ST_WR);
      mem_we_d   = (state_d == S_ST_WR);
      rf_addr_d  = (state_d == S_IDLE) ? '0 : rd_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rd_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rf_write  <= 1'b0;
         rf_addr   <= '0;
         rf_wdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         busy      <= busy_d;
         done      <= done_d;
         rf_write  <= rf_write_d;
         rf_addr   <= rf_addr_d;
         rf_wdata  <= data_d;
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= addr_d;
         mem_wdata <= data_d;
      end
   end

`ifdef LSU_ADDR_CHECK_EN
   logic err_d;

   assign range_err_c = (32'(addr) >= MEM_DEPTH);
   assign err_d       = (state_d == S_ERR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err <= 1'b0;
      else        err <= err_d;
   end
`else
   assign range_err_c = 1'b0;
   assign err         = 1'b0;

   // MEM_DEPTH only shapes the range comparator, which this build omits
   if (MEM_DEPTH == 0) begin : g_depth_unused
   end
`endif

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer that drives the register-file port (write enable, shared 3-bit address, 8-bit write data, combinational 8-bit read data) and a synchronous data memory. It executes one LOAD (memory to register) or STORE (register to memory) per `start` pulse. It sits between instruction decode and the 8x8 register file, and is the only agent that asserts the register-file write enable in the load/store path.

## Interface
- `AW`, 4: data-memory address width.
- `MEM_DEPTH`, 16: number of valid memory words. Valid addresses are 0..MEM_DEPTH-1. Used only with `LSU_ADDR_CHECK_EN`.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: operation request. Sampled only in IDLE.
- `op` in 1: 0 = LOAD, 1 = STORE. Sampled with `start`.
- `rd` in 3: register index. Sampled with `start`.
- `addr` in AW: memory address. Sampled with `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: high for exactly one cycle, the final cycle of an operation.
- `err` out 1: address-range error pulse. Tied 0 without the macro.
- `rf_write` out 1: register-file write enable.
- `rf_addr` out 3: register-file address, shared by read and write.
- `rf_wdata` out 8: register-file write data.
- `rf_rdata` in 8: register-file combinational read data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable. Qualified by `mem_en`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data, valid the cycle after a read strobe.

## Operation
- States: IDLE, LD_REQ, LD_CAP, LD_WB, ST_RD, ST_WR, ERR. Encoding is free.
- Internal registers: `rd_q` (3), `addr_q` (AW), `data_q` (8). All are loaded in IDLE when `start`=1.
- IDLE with `start`=1:
  - `op`=0 goes to LD_REQ.
  - `op`=1 goes to ST_RD.
  - Range failure (macro only) goes to ERR.
- IDLE with `start`=0 stays in IDLE.
- LD_REQ: `mem_en`=1, `mem_we`=0, `mem_addr`=`addr_q`. Next state LD_CAP.
- LD_CAP: `data_q` <= `mem_rdata` at the end of the cycle. Next state LD_WB.
- LD_WB: `rf_write`=1, `rf_addr`=`rd_q`, `rf_wdata`=`data_q`, `done`=1. Next state IDLE.
- ST_RD: `rf_addr`=`rd_q`; `data_q` <= `rf_rdata` at the end of the cycle. Next state ST_WR.
- ST_WR: `mem_en`=1, `mem_we`=1, `mem_addr`=`addr_q`, `mem_wdata`=`data_q`, `done`=1. Next state IDLE.
- ERR: `done`=1, `err`=1. No memory strobe and no register write. Next state IDLE.
- Default output values, in any state that does not drive them:
  - `rf_write`, `mem_en`, `mem_we` = 0.
  - `rf_addr` = `rd_q` in non-IDLE states, 0 in IDLE.
  - `mem_addr` = `addr_q`.
  - `rf_wdata` and `mem_wdata` = `data_q`.
- `start` while busy, including the `done` cycle, is ignored with no side effects. It is not queued.
- LOAD with `rd` = 0 writes r0 normally. There are no special registers.

## Timing
- Reset, asynchronous and active-low: state = IDLE, `rd_q`/`addr_q`/`data_q` = 0, all outputs 0.
- Reset mid-operation abandons the operation immediately. No `rf_write` or `mem_en` is issued after reset asserts. `done` is not issued for the aborted operation.
- Cycle numbering: the start edge ends cycle 0; the operation begins in cycle 1.
- LOAD: LD_REQ in cycle 1, LD_CAP in cycle 2, LD_WB in cycle 3. The register is updated at the end of cycle 3. Busy for 3 cycles.
- STORE: ST_RD in cycle 1, ST_WR in cycle 2. Memory is written at the end of cycle 2. Busy for 2 cycles.
- ERR: 1 cycle (cycle 1).
- Back-to-back: the earliest next accept is the cycle after `done`. Throughput is 1 LOAD per 4 cycles and 1 STORE per 3 cycles.
- The memory must have 1-cycle synchronous read latency. The register-file read must be combinational within the ST_RD cycle.
- All outputs are Moore functions of state and internal registers. There are no combinational input-to-output paths.

## Configuration
- Macro: `LSU_ADDR_CHECK_EN`.
- Defined:
  - `start` with `addr` >= `MEM_DEPTH` enters ERR. `addr` = `MEM_DEPTH`-1 is legal.
  - `MEM_DEPTH` = 2^AW makes the check vacuous.
- Undefined:
  - No comparator is built and `err` = 0.
  - Every address proceeds and wraps naturally within AW bits.

## Test plan
- Reset, then STORE with `rd`=5, `addr`=3 (register-file reset contents r5=0x05) -> in cycle 2: `mem_en`=`mem_we`=1, `mem_addr`=3, `mem_wdata`=0x05, `done`=1. `busy` is high for 2 cycles only.
- Memory[7]=0xA5, LOAD with `rd`=2, `addr`=7 -> `mem_en`=1 with `mem_we`=0 in cycle 1. Single `rf_write` pulse in cycle 3 with `rf_addr`=2, `rf_wdata`=0xA5. Register-file r2 then reads 0xA5.
- LOAD in progress, pulse `start` with `op`=1, `rd`=6 during LD_CAP and again during LD_WB -> no ST_RD/ST_WR, no extra `mem_en` or `done`. The next op is accepted only from IDLE.
- STORE r4 to addr 9, then LOAD r1 from addr 9 with `start` in the cycle after `done` -> LOAD accepted immediately; r1 = 0x04; `done` pulses at cycles 2 and 6.
- Assert `reset` during LD_CAP of LOAD r3 from memory 0xFF -> `rf_write` is never asserted. All outputs go to 0 immediately. r3 keeps its reset value 0x03.
- With `LSU_ADDR_CHECK_EN`, `MEM_DEPTH`=12: LOAD from `addr`=13 -> `err`=`done`=1 for exactly one cycle, no `mem_en`, no `rf_write`. `addr`=11 completes normally.
